// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared CPU definitions: opcodes, control-unit state encodings, ALUOp, PCSrc and RegDst codes.
package cpu_pkg;
    localparam int OPW = 6;
    localparam int STW = 4;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
    localparam logic [OPW-1:0] OP_SLTIU = 6'b101000;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [STW-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_WB_AL  = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_EXE_LS = 4'b0101,
        S_MEM    = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;
endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Control-unit bundle: IR opcode and ALU flags in, datapath enables/selects and debug state out.
interface multi_cycle_control_unit_if;
    logic [cpu_pkg::OPW-1:0] opcode;
    logic                    zero;
    logic                    sign;
    logic                    PCWre;
    logic                    IRWre;
    logic                    InsMemRW;
    logic                    RegWre;
    logic                    ALUSrcA;
    logic                    ALUSrcB;
    logic [2:0]              ALUOp;
    logic                    ExtSel;
    logic                    mRD;
    logic                    mWR;
    logic                    DBDataSrc;
    logic                    WrRegDSrc;
    logic [1:0]              RegDst;
    logic [1:0]              PCSrc;
    logic [cpu_pkg::STW-1:0] state;

    // Control signals are level-qualified per cycle; there is no valid/ready handshake on this bundle.
    modport master (
        input  opcode, zero, sign,
        output PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
               mRD, mWR, DBDataSrc, WrRegDSrc, RegDst, PCSrc, state
    );
    modport slave (
        output opcode, zero, sign,
        input  PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
               mRD, mWR, DBDataSrc, WrRegDSrc, RegDst, PCSrc, state
    );
endinterface

// File: rtl/multi_cycle_control_unit_opdecode.sv
// Combinational opcode-class decode: instruction class flags plus ALUOp and extension select.
module cu_opdecode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output logic           is_rtype_o,
    output logic           is_imm_o,
    output logic           is_branch_o,
    output logic           is_mem_o,
    output logic           is_jump_o,
    output logic           is_halt_o,
    output logic [2:0]     aluop_o,
    output logic           extsel_o
);
    always_comb begin
        is_rtype_o  = 1'b0;
        is_imm_o    = 1'b0;
        is_branch_o = 1'b0;
        is_mem_o    = 1'b0;
        is_jump_o   = 1'b0;
        is_halt_o   = 1'b0;
        aluop_o     = ALU_ADD;
        extsel_o    = 1'b0;
        case (opcode_i)
            OP_ADD:   begin is_rtype_o = 1'b1; aluop_o = ALU_ADD; end
            OP_SUB:   begin is_rtype_o = 1'b1; aluop_o = ALU_SUB; end
            OP_AND:   begin is_rtype_o = 1'b1; aluop_o = ALU_AND; end
            OP_SLL:   begin is_rtype_o = 1'b1; aluop_o = ALU_SLL; end
            OP_SLT:   begin is_rtype_o = 1'b1; aluop_o = ALU_SLT; end
            OP_ADDIU: begin is_imm_o = 1'b1; aluop_o = ALU_ADD;  extsel_o = 1'b1; end
            OP_ANDI:  begin is_imm_o = 1'b1; aluop_o = ALU_AND; end
            OP_ORI:   begin is_imm_o = 1'b1; aluop_o = ALU_OR; end
            OP_XORI:  begin is_imm_o = 1'b1; aluop_o = ALU_XOR; end
            OP_SLTI:  begin is_imm_o = 1'b1; aluop_o = ALU_SLT;  extsel_o = 1'b1; end
            OP_SLTIU: begin is_imm_o = 1'b1; aluop_o = ALU_SLTU; extsel_o = 1'b1; end
            OP_SW, OP_LW: begin is_mem_o = 1'b1; extsel_o = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin is_branch_o = 1'b1; aluop_o = ALU_SUB; extsel_o = 1'b1; end
            OP_J, OP_JR, OP_JAL: is_jump_o = 1'b1;
            OP_HALT:  is_halt_o = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU sequencing FSM; outputs are combinational from state, opcode and ALU flags.
// Build option CU_ILLEGAL_TRAP_EN: unrecognised opcodes halt and raise 'illegal' instead of acting as nop.
module multi_cycle_control_unit
    import cpu_pkg::*;
(
    input logic                        CLK,
    input logic                        RST,
    multi_cycle_control_unit_if.master bus
`ifdef CU_ILLEGAL_TRAP_EN
    , output logic                     illegal
`endif
);
    state_t     state_q, state_d;
    logic       is_rtype, is_imm, is_branch, is_mem, is_jump, is_halt, dec_extsel;
    logic [2:0] dec_aluop;
    logic       pc_wre, ir_wre, ins_mem_rw, reg_wre, alu_src_a, alu_src_b, ext_sel;
    logic       m_rd, m_wr, db_data_src, wr_reg_d_src, taken;
    logic [2:0] alu_op;
    logic [1:0] reg_dst, pc_src;

    cu_opdecode u_opdecode (
        .opcode_i    (bus.opcode),
        .is_rtype_o  (is_rtype),
        .is_imm_o    (is_imm),
        .is_branch_o (is_branch),
        .is_mem_o    (is_mem),
        .is_jump_o   (is_jump),
        .is_halt_o   (is_halt),
        .aluop_o     (dec_aluop),
        .extsel_o    (dec_extsel)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IF;
        else     state_q <= state_d;
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge CLK) begin
        if (RST)
            illegal_q <= 1'b0;
        else if (state_q == S_ID && !(is_rtype || is_imm || is_branch || is_mem || is_jump || is_halt))
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`endif

    assign taken = (bus.opcode == OP_BEQ  &&  bus.zero) ||
                   (bus.opcode == OP_BNE  && !bus.zero) ||
                   (bus.opcode == OP_BLTZ &&  bus.sign);

    always_comb begin
        pc_wre = 1'b0; ir_wre = 1'b0; ins_mem_rw = 1'b0; reg_wre = 1'b0;
        alu_src_a = 1'b0; alu_src_b = 1'b0; alu_op = ALU_ADD; ext_sel = 1'b0;
        m_rd = 1'b0; m_wr = 1'b0; db_data_src = 1'b0; wr_reg_d_src = 1'b0;
        reg_dst = RD_RA; pc_src = PC_NEXT;
        state_d = S_IF;
        // Reset shows the fetch pattern but with both write enables held low.
        if (RST) begin
            ins_mem_rw = 1'b1;
        end else begin
            case (state_q)
                S_IF: begin
                    ins_mem_rw = 1'b1;
                    ir_wre     = 1'b1;
                    state_d    = S_ID;
                end
                S_ID: begin
                    if (is_jump) begin
                        pc_wre  = 1'b1;
                        pc_src  = (bus.opcode == OP_JR) ? PC_RS : PC_JUMP;
                        reg_wre = (bus.opcode == OP_JAL);
                        state_d = S_IF;
                    end else if (is_halt) begin
                        state_d = S_HALT;
                    end else if (is_branch) begin
                        state_d = S_EXE_BR;
                    end else if (is_mem) begin
                        state_d = S_EXE_LS;
                    end else if (is_rtype || is_imm) begin
                        state_d = S_EXE_AL;
                    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        pc_wre  = 1'b1;
                        state_d = S_IF;
`endif
                    end
                end
                S_EXE_AL: begin
                    alu_op    = dec_aluop;
                    alu_src_a = (bus.opcode == OP_SLL);
                    alu_src_b = is_imm;
                    ext_sel   = dec_extsel;
                    state_d   = S_WB_AL;
                end
                S_WB_AL: begin
                    reg_wre      = 1'b1;
                    wr_reg_d_src = 1'b1;
                    reg_dst      = is_rtype ? RD_RD : RD_RT;
                    pc_wre       = 1'b1;
                end
                S_EXE_BR: begin
                    alu_op  = ALU_SUB;
                    ext_sel = 1'b1;
                    pc_wre  = 1'b1;
                    pc_src  = taken ? PC_BRANCH : PC_NEXT;
                end
                S_EXE_LS: begin
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                    state_d   = S_MEM;
                end
                S_MEM: begin
                    if (bus.opcode == OP_LW) begin
                        m_rd    = 1'b1;
                        state_d = S_WB_LD;
                    end else begin
                        m_wr   = 1'b1;
                        pc_wre = 1'b1;
                    end
                end
                S_WB_LD: begin
                    m_rd         = 1'b1;
                    reg_wre      = 1'b1;
                    reg_dst      = RD_RT;
                    wr_reg_d_src = 1'b1;
                    db_data_src  = 1'b1;
                    pc_wre       = 1'b1;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end
    end

    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.InsMemRW  = ins_mem_rw;
    assign bus.RegWre    = reg_wre;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ExtSel    = ext_sel;
    assign bus.mRD       = m_rd;
    assign bus.mWR       = m_wr;
    assign bus.DBDataSrc = db_data_src;
    assign bus.WrRegDSrc = wr_reg_d_src;
    assign bus.RegDst    = reg_dst;
    assign bus.PCSrc     = pc_src;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: per-cycle expected control vectors queued per instruction.
module tb_multi_cycle_control_unit;
    import cpu_pkg::*;

    localparam int W = 22;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    logic [5:0]   ops [18] = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI, OP_SLL,
                               OP_SLTI, OP_SLT, OP_SLTIU, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
                               OP_J, OP_JAL};

    multi_cycle_control_unit_if bus ();
`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal;
`endif

    multi_cycle_control_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
`ifdef CU_ILLEGAL_TRAP_EN
        , .illegal (illegal)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Vector layout: state, {PCWre,IRWre,InsMemRW,RegWre,ALUSrcA,ALUSrcB}, ALUOp,
    // {ExtSel,mRD,mWR,DBDataSrc,WrRegDSrc}, RegDst, PCSrc.
    assign dut_vec = {bus.state, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.ALUSrcA,
                      bus.ALUSrcB, bus.ALUOp, bus.ExtSel, bus.mRD, bus.mWR, bus.DBDataSrc,
                      bus.WrRegDSrc, bus.RegDst, bus.PCSrc};

    function automatic logic [W-1:0] v(input logic [3:0] st, input logic [5:0] en, input logic [2:0] aop,
                                       input logic [4:0] misc, input logic [1:0] rd, input logic [1:0] pcs);
        return {st, en, aop, misc, rd, pcs};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) check("cycle", dut_vec, exp_q.pop_front());
    end

    task automatic push_alu(input logic [2:0] aop, input logic sa, input logic sb, input logic ext,
                            input logic [1:0] rd);
        exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
        exp_q.push_back(v(4'h2, {4'b0000, sa, sb}, aop, {ext, 4'b0000}, 2'b00, 2'b00));
        exp_q.push_back(v(4'h3, 6'b100100, 3'b000, 5'b00001, rd, 2'b00));
    endtask

    task automatic wait_drain(input int n);
        repeat (n) @(posedge CLK);
        #1;
        check("drain", W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    // Called just after a rising edge that leaves the DUT in IF.
    task automatic issue(input logic [5:0] op, input logic z, input logic s);
        logic tk;
        bus.opcode = op;
        bus.zero   = z;
        bus.sign   = s;
        exp_q.push_back(v(4'h0, 6'b011000, 3'b000, 5'b00000, 2'b00, 2'b00));
        case (op)
            OP_ADD:   push_alu(3'b000, 1'b0, 1'b0, 1'b0, 2'b10);
            OP_SUB:   push_alu(3'b001, 1'b0, 1'b0, 1'b0, 2'b10);
            OP_AND:   push_alu(3'b110, 1'b0, 1'b0, 1'b0, 2'b10);
            OP_SLL:   push_alu(3'b100, 1'b1, 1'b0, 1'b0, 2'b10);
            OP_SLT:   push_alu(3'b010, 1'b0, 1'b0, 1'b0, 2'b10);
            OP_ADDIU: push_alu(3'b000, 1'b0, 1'b1, 1'b1, 2'b01);
            OP_ANDI:  push_alu(3'b110, 1'b0, 1'b1, 1'b0, 2'b01);
            OP_ORI:   push_alu(3'b101, 1'b0, 1'b1, 1'b0, 2'b01);
            OP_XORI:  push_alu(3'b111, 1'b0, 1'b1, 1'b0, 2'b01);
            OP_SLTI:  push_alu(3'b010, 1'b0, 1'b1, 1'b1, 2'b01);
            OP_SLTIU: push_alu(3'b011, 1'b0, 1'b1, 1'b1, 2'b01);
            OP_SW, OP_LW: begin
                exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
                exp_q.push_back(v(4'h5, 6'b000001, 3'b000, 5'b10000, 2'b00, 2'b00));
                if (op == OP_SW) begin
                    exp_q.push_back(v(4'h6, 6'b100000, 3'b000, 5'b00100, 2'b00, 2'b00));
                end else begin
                    exp_q.push_back(v(4'h6, 6'b000000, 3'b000, 5'b01000, 2'b00, 2'b00));
                    exp_q.push_back(v(4'h7, 6'b100100, 3'b000, 5'b01011, 2'b01, 2'b00));
                end
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                tk = (op == OP_BEQ) ? z : (op == OP_BNE) ? !z : s;
                exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
                exp_q.push_back(v(4'h4, 6'b100000, 3'b001, 5'b10000, 2'b00, tk ? 2'b01 : 2'b00));
            end
            OP_J:   exp_q.push_back(v(4'h1, 6'b100000, 3'b000, 5'b00000, 2'b00, 2'b11));
            OP_JR:  exp_q.push_back(v(4'h1, 6'b100000, 3'b000, 5'b00000, 2'b00, 2'b10));
            OP_JAL: exp_q.push_back(v(4'h1, 6'b100100, 3'b000, 5'b00000, 2'b00, 2'b11));
            OP_HALT: begin
                exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
                repeat (10) exp_q.push_back(v(4'h8, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
            end
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
                repeat (3) exp_q.push_back(v(4'h8, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
`else
                exp_q.push_back(v(4'h1, 6'b100000, 3'b000, 5'b00000, 2'b00, 2'b00));
`endif
            end
        endcase
        wait_drain(exp_q.size());
    endtask

    // Reset from the current state: one cycle of fetch-like outputs with writes suppressed.
    task automatic apply_reset(input logic [3:0] cur_state);
        RST = 1'b1;
        exp_q.push_back(v(cur_state, 6'b001000, 3'b000, 5'b00000, 2'b00, 2'b00));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_drain", W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    initial begin
        RST        = 1'b1;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        exp_q.push_back(v(4'h0, 6'b001000, 3'b000, 5'b00000, 2'b00, 2'b00));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();

        issue(OP_ADD, 1'b0, 1'b0);
        issue(OP_LW, 1'b0, 1'b0);
        issue(OP_SW, 1'b0, 1'b0);
        issue(OP_BEQ, 1'b1, 1'b0);
        issue(OP_BEQ, 1'b0, 1'b0);
        issue(OP_BNE, 1'b0, 1'b1);
        issue(OP_BLTZ, 1'b0, 1'b1);
        issue(OP_BLTZ, 1'b1, 1'b0);
        issue(OP_JAL, 1'b0, 1'b0);
        issue(OP_JR, 1'b0, 1'b0);
        issue(OP_J, 1'b0, 1'b0);
        issue(OP_SLL, 1'b0, 1'b0);
        issue(OP_ADDIU, 1'b0, 1'b0);
        issue(OP_ORI, 1'b0, 1'b0);
        issue(OP_SLTIU, 1'b0, 1'b0);

        // Reset during MEM of sw: no mWR, back to IF on the next edge.
        bus.opcode = OP_SW;
        exp_q.push_back(v(4'h0, 6'b011000, 3'b000, 5'b00000, 2'b00, 2'b00));
        exp_q.push_back(v(4'h1, 6'b000000, 3'b000, 5'b00000, 2'b00, 2'b00));
        exp_q.push_back(v(4'h5, 6'b000001, 3'b000, 5'b10000, 2'b00, 2'b00));
        repeat (3) @(posedge CLK);
        #1;
        apply_reset(4'h6);
        issue(OP_ADD, 1'b0, 1'b0);

        issue(OP_HALT, 1'b0, 1'b0);
        apply_reset(4'h8);

        issue(6'b001111, 1'b0, 1'b0);
`ifdef CU_ILLEGAL_TRAP_EN
        check("illegal_set", W'(illegal), W'(1));
        apply_reset(4'h8);
        check("illegal_clr", W'(illegal), W'(0));
`endif

        for (int i = 0; i < 24; i++) begin
            issue(ops[$urandom_range(0, 17)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Sequencing FSM of the multi-cycle CPU. It decodes the 6-bit opcode held in the instruction register.
- Drives every datapath enable and mux select, including the 3-bit ALUOp consumed by the ALU.
- Consumes the ALU's zero/sign flags to resolve branches.
- One instance sits between the instruction register and the datapath (PC, register file, data memory, ALU).

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- CLK  in  1  system clock, rising edge. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous reset, active-high.
- opcode  in  6  IR[31:26], stable from ID onward.
- zero  in  1  ALU result==0.
- sign  in  1  ALU result[31].
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- InsMemRW  out  1  1 = instruction memory read.
- RegWre  out  1  register file write enable.
- ALUSrcA  out  1  0 = rs data, 1 = zero-extended sa.
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate.
- ALUOp  out  3  000 add, 001 sub, 010 signed slt, 011 unsigned slt, 100 B<<A, 101 or, 110 and, 111 xor.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB bus.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = {PC[31:28], addr, 00}.
- state  out  STW  current state, for debug.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011, sll 011000
  - slti 100110, slt 100111, sltiu 101000
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- States: IF=0000, ID=0001, EXE_AL=0010, WB_AL=0011, EXE_BR=0100, EXE_LS=0101, MEM=0110, WB_LD=0111, HALT=1000.
- Only the state register is sequential. All outputs are combinational from state, opcode, zero and sign.
- Reset: state=IF on the next edge. While RST=1, outputs take their IF values except PCWre=0 and IRWre=0, so no write occurs during reset. RST mid-instruction aborts it; no RegWre/mWR is issued afterwards.
- Default for any output not listed below: 0.
- IF: InsMemRW=1, IRWre=1. Next: ID.
- ID:
  - j, jr, jal: PCWre=1 with PCSrc 11, 10, 11 respectively.
  - jal also asserts RegWre=1, RegDst=00, WrRegDSrc=0.
  - Next state: IF after j/jr/jal; HALT for halt; EXE_BR for branches; EXE_LS for sw/lw; EXE_AL otherwise.
- EXE_AL:
  - ALUOp from opcode.
  - ALUSrcB=1 for immediate forms; ALUSrcA=1 for sll.
  - ExtSel=1 for addiu, slti, sltiu; 0 for andi, ori, xori.
  - Next: WB_AL.
- WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type, 01 for I-type. PCWre=1, PCSrc=00. Next: IF.
- EXE_BR:
  - ALUOp=001.
  - Taken when: beq and zero=1; bne and zero=0; bltz and sign=1.
  - PCWre=1; PCSrc=01 if taken, else 00; ExtSel=1.
  - Next: IF.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1. Next: MEM.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00, next IF.
  - lw: mRD=1, next WB_LD.
- WB_LD: mRD=1, RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1. PCWre=1, PCSrc=00. Next: IF.
- HALT: all enables 0; stays until RST.
- PCWre is asserted in exactly one cycle per instruction: the last one. The PC therefore updates on the edge entering IF.
- Latency in cycles: j/jr/jal 2, branch 3, R/I ALU 4, sw 4, lw 5.
- Undefined encodings of state (1001..1111) go to IF on the next edge.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- When defined: an unrecognised opcode in ID moves to HALT. An extra output port illegal (1 bit) is high while in HALT via this path. It is cleared only by RST.
- When undefined: an unrecognised opcode is a nop. ID asserts PCWre=1 with PCSrc=00 and moves to IF; no illegal port exists.

Decomposition:
- Shared package cpu_pkg holds: opcode localparams, state encodings, ALUOp encodings (shared with the ALU), PCSrc/RegDst encodings.
- One sub-module, cu_opdecode: combinational opcode-class decode (is_rtype, is_imm, is_branch, is_mem, is_jump, aluop, extsel). The top level holds the FSM and output muxing.

Test Plan:
- RST=1 for 2 edges, then release with opcode=000000 -> state=0000; cycle 1 InsMemRW=1, IRWre=1; PCWre=0 during reset.
- add (000000) -> states 0,1,2,3,0; ALUOp=000 in EXE_AL; RegWre=1, RegDst=10, PCWre=1 only in WB_AL.
- lw (110001) -> 0,1,5,6,7,0; WB_LD has DBDataSrc=1, RegDst=01; sw (110000) gives mWR=1 only in MEM, 4 cycles total.
- beq with zero=1 -> PCSrc=01 in EXE_BR; zero=0 -> PCSrc=00; bltz with sign=1 -> PCSrc=01; all 3 cycles.
- jal (111010) -> 2 cycles; ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. halt (111111) -> state 1000 held 10 cycles, all enables 0.
- RST asserted in MEM of sw -> mWR=0 that cycle, state=0000 next edge. Opcode 001111 -> HALT and illegal=1 with CU_ILLEGAL_TRAP_EN; 2-cycle nop without it.
